decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Synthesizable LC-3 pipeline Decode stage; sink end of the decode_in interface.
- Captures instr_dout, npc_in and Sr from Fetch/Writeback when en_decode is high.
- Registers IR, NPC and PSR forward, and generates E_Control, W_Control and Mem_Control for Execute/Writeback/MemAccess.
- One-cycle registered latency; holds state while disabled.

Parameters:
DATA_W, 16, instruction/NPC width
PSR_W, 3, PSR NZP width

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  synchronous, active-high
instr_dout  in  DATA_W  instruction word from instruction memory
npc_in  in  DATA_W  PC+1 from Fetch
Sr  in  PSR_W  current NZP flags
en_decode  in  1  capture enable from controller
IR  out  DATA_W  registered instruction
npc_out  out  DATA_W  registered NPC
Sr_out  out  PSR_W  registered NZP for branch resolution
E_Control  out  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
W_Control  out  2  writeback mux select
Mem_Control  out  1  indirect memory access flag
dec_valid  out  1  outputs updated this cycle

Behaviour:
- Reset (sampled at posedge): all outputs go to 0, including IR, npc_out, Sr_out, all controls and dec_valid. Reset has priority over en_decode. A mid-stream reset discards the in-flight capture.
- en_decode=1 at posedge:
  - IR<=instr_dout, npc_out<=npc_in, Sr_out<=Sr.
  - Control fields are decoded from instr_dout, not from the old IR.
  - dec_valid<=1.
- en_decode=0 at posedge: all data/control outputs hold; dec_valid<=0.
- Back-to-back enables give one new decode per cycle; there is no bubble.
- Opcode = instr_dout[15:12].
- alu_control: ADD(0001)=00, AND(0101)=01, NOT(1001)=10, all others 00.
- op2select: 1 selects VSR2, 0 selects imm5. ADD/AND use op2select=~instr_dout[5]; all others 0.
- pcselect1 / pcselect2:
  - BR(0000), LD(0010), LDI(1010), ST(0011), STI(1011), LEA(1110): pcselect1=01 (offset9), pcselect2=1 (NPC).
  - LDR(0110), STR(0111): pcselect1=10 (offset6), pcselect2=0 (VSR1).
  - JMP(1100): pcselect1=11 (zero), pcselect2=0.
  - ALU ops: pcselect1=00, pcselect2=0.
- W_Control: LD/LDR/LDI=01 (memout); LEA=10 (pcout); all others 00 (aluout).
- Mem_Control: 1 for LDI and STI only.
- Unsupported opcodes (0100, 1000, 1101, 1111): capture as normal, all controls 0.
- No arithmetic beyond field extraction; no internal state besides the output registers.

Optional Feature:
DECODE_ILLEGAL_OP_EN
- Defined:
  - Adds output illegal_op (1 bit), reset 0.
  - Registered with the other outputs on en_decode; 1 when the captured opcode is in {0100, 1000, 1101, 1111}, else 0.
  - Holds when en_decode=0.
- Undefined: the port is absent and behaviour is otherwise identical.

Decomposition:
- decode_pkg holds:
  - opcode_t enum (OP_BR…OP_LEA, 4-bit)
  - localparams for alu_control codes (ALU_ADD/AND/NOT)
  - pcselect1 codes (PC1_OFF11/OFF9/OFF6/ZERO)
  - W_Control codes (WB_ALU/MEM/PC)
  - E_Control bit positions
- One combinational sub-module, decode_ctrl_lut:
  - input: instr word
  - outputs: E_Control, W_Control, Mem_Control (and illegal under the macro)
  - decode_stage instantiates it and registers its outputs.

Test Plan:
1. reset=1 for 2 cycles with en_decode=1, instr_dout=16'h1234 -> all outputs 0, dec_valid=0; release -> next enabled edge captures normally.
2. en_decode=1, instr_dout=16'h1042 (ADD R0,R1,R2), npc_in=16'h3001, Sr=3'b010 -> after 1 edge: IR=1042, npc_out=3001, Sr_out=010, E_Control=6'b000001, W=00, Mem=0, dec_valid=1. Next cycle 16'h1065 (ADD imm) -> E_Control=000000.
3. instr_dout=16'hA403 (LDI), npc_in=16'h3005 -> E_Control=6'b000110, W_Control=01, Mem_Control=1; then 16'h6A42 (LDR) -> E_Control=001000, W=01, Mem=0.
4. After capturing 16'hE5FF (LEA), drop en_decode and drive instr_dout=16'h5000 for 3 cycles -> IR stays E5FF, E_Control=000110, W=10, dec_valid=0 all 3 cycles.
5. Capture 16'hC1C0 (JMP R7) and assert reset on the same edge as en_decode -> outputs 0; following enabled edge -> E_Control=001100, W=00.
6. With DECODE_ILLEGAL_OP_EN, capture 16'hD000 then 16'h9A7F (NOT) -> illegal_op 1 then 0; NOT gives E_Control=100000.

Source files
------------

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - LC-3 decode opcodes, control codes and E_Control bit positions
package decode_pkg;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LD   = 4'b0010,
        OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_RES  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } opcode_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_NOT = 2'b10;

    localparam logic [1:0] PC1_OFF11 = 2'b00;
    localparam logic [1:0] PC1_OFF9  = 2'b01;
    localparam logic [1:0] PC1_OFF6  = 2'b10;
    localparam logic [1:0] PC1_ZERO  = 2'b11;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    // E_Control = {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
    localparam int E_ALU_HI = 5;
    localparam int E_ALU_LO = 4;
    localparam int E_PC1_HI = 3;
    localparam int E_PC1_LO = 2;
    localparam int E_PC2    = 1;
    localparam int E_OP2    = 0;

endpackage

// File: rtl/decode_ctrl_lut.sv
// rtl/decode_ctrl_lut.sv - combinational LC-3 control decode; illegal output under DECODE_ILLEGAL_OP_EN
module decode_ctrl_lut
    import decode_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] instr,
    output logic [5:0]        e_control,
    output logic [1:0]        w_control,
    output logic              mem_control
`ifdef DECODE_ILLEGAL_OP_EN
    ,
    output logic              illegal
`endif
);

    opcode_t w_op;
    logic    w_unused_bits;

    assign w_op          = opcode_t'(instr[DATA_W-1 -: 4]);
    assign w_unused_bits = ^{instr[DATA_W-5:6], instr[4:0]};

    always_comb begin
        e_control   = '0;
        w_control   = WB_ALU;
        mem_control = 1'b0;
`ifdef DECODE_ILLEGAL_OP_EN
        illegal     = 1'b0;
`endif
        case (w_op)
            OP_ADD: begin
                e_control[E_ALU_HI:E_ALU_LO] = ALU_ADD;
                e_control[E_OP2]             = ~instr[5];
            end
            OP_AND: begin
                e_control[E_ALU_HI:E_ALU_LO] = ALU_AND;
                e_control[E_OP2]             = ~instr[5];
            end
            OP_NOT: e_control[E_ALU_HI:E_ALU_LO] = ALU_NOT;
            OP_BR, OP_ST: begin
                e_control[E_PC1_HI:E_PC1_LO] = PC1_OFF9;
                e_control[E_PC2]             = 1'b1;
            end
            OP_LD: begin
                e_control[E_PC1_HI:E_PC1_LO] = PC1_OFF9;
                e_control[E_PC2]             = 1'b1;
                w_control                    = WB_MEM;
            end
            OP_LDI: begin
                e_control[E_PC1_HI:E_PC1_LO] = PC1_OFF9;
                e_control[E_PC2]             = 1'b1;
                w_control                    = WB_MEM;
                mem_control                  = 1'b1;
            end
            OP_STI: begin
                e_control[E_PC1_HI:E_PC1_LO] = PC1_OFF9;
                e_control[E_PC2]             = 1'b1;
                mem_control                  = 1'b1;
            end
            OP_LEA: begin
                e_control[E_PC1_HI:E_PC1_LO] = PC1_OFF9;
                e_control[E_PC2]             = 1'b1;
                w_control                    = WB_PC;
            end
            OP_LDR: begin
                e_control[E_PC1_HI:E_PC1_LO] = PC1_OFF6;
                w_control                    = WB_MEM;
            end
            OP_STR: e_control[E_PC1_HI:E_PC1_LO] = PC1_OFF6;
            OP_JMP: e_control[E_PC1_HI:E_PC1_LO] = PC1_ZERO;
            default: begin
                // JSR, RTI, reserved and TRAP are not executed by this pipeline
`ifdef DECODE_ILLEGAL_OP_EN
                illegal = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - LC-3 Decode stage registers; optional illegal_op port under DECODE_ILLEGAL_OP_EN
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PSR_W  = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] instr_dout,
    input  logic [DATA_W-1:0] npc_in,
    input  logic [PSR_W-1:0]  Sr,
    input  logic              en_decode,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] npc_out,
    output logic [PSR_W-1:0]  Sr_out,
    output logic [5:0]        E_Control,
    output logic [1:0]        W_Control,
    output logic              Mem_Control,
`ifdef DECODE_ILLEGAL_OP_EN
    output logic              illegal_op,
`endif
    output logic              dec_valid
);

    logic [5:0] w_e_control;
    logic [1:0] w_w_control;
    logic       w_mem_control;

    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_npc;
    logic [PSR_W-1:0]  r_sr;
    logic [5:0]        r_e_control;
    logic [1:0]        r_w_control;
    logic              r_mem_control;
    logic              r_dec_valid;

`ifdef DECODE_ILLEGAL_OP_EN
    logic w_illegal;
    logic r_illegal;
`endif

    // Controls come from the incoming word so they line up with the IR captured on the same edge
    decode_ctrl_lut #(.DATA_W(DATA_W)) u_lut (
        .instr       (instr_dout),
        .e_control   (w_e_control),
        .w_control   (w_w_control),
        .mem_control (w_mem_control)
`ifdef DECODE_ILLEGAL_OP_EN
        ,
        .illegal     (w_illegal)
`endif
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ir          <= '0;
            r_npc         <= '0;
            r_sr          <= '0;
            r_e_control   <= '0;
            r_w_control   <= '0;
            r_mem_control <= 1'b0;
            r_dec_valid   <= 1'b0;
`ifdef DECODE_ILLEGAL_OP_EN
            r_illegal     <= 1'b0;
`endif
        end else if (en_decode) begin
            r_ir          <= instr_dout;
            r_npc         <= npc_in;
            r_sr          <= Sr;
            r_e_control   <= w_e_control;
            r_w_control   <= w_w_control;
            r_mem_control <= w_mem_control;
            r_dec_valid   <= 1'b1;
`ifdef DECODE_ILLEGAL_OP_EN
            r_illegal     <= w_illegal;
`endif
        end else begin
            r_dec_valid   <= 1'b0;
        end
    end

    assign IR          = r_ir;
    assign npc_out     = r_npc;
    assign Sr_out      = r_sr;
    assign E_Control   = r_e_control;
    assign W_Control   = r_w_control;
    assign Mem_Control = r_mem_control;
    assign dec_valid   = r_dec_valid;
`ifdef DECODE_ILLEGAL_OP_EN
    assign illegal_op  = r_illegal;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed vector bench for decode_stage; checks illegal_op under DECODE_ILLEGAL_OP_EN
module tb_decode_stage;

    logic        clock;
    logic        reset;
    logic [15:0] instr_dout;
    logic [15:0] npc_in;
    logic [2:0]  Sr;
    logic        en_decode;
    logic [15:0] IR;
    logic [15:0] npc_out;
    logic [2:0]  Sr_out;
    logic [5:0]  E_Control;
    logic [1:0]  W_Control;
    logic        Mem_Control;
    logic        dec_valid;
`ifdef DECODE_ILLEGAL_OP_EN
    logic        illegal_op;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    decode_stage #(.DATA_W(16), .PSR_W(3)) dut (
        .clock       (clock),
        .reset       (reset),
        .instr_dout  (instr_dout),
        .npc_in      (npc_in),
        .Sr          (Sr),
        .en_decode   (en_decode),
        .IR          (IR),
        .npc_out     (npc_out),
        .Sr_out      (Sr_out),
        .E_Control   (E_Control),
        .W_Control   (W_Control),
        .Mem_Control (Mem_Control),
`ifdef DECODE_ILLEGAL_OP_EN
        .illegal_op  (illegal_op),
`endif
        .dec_valid   (dec_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        en;
        logic [15:0] instr;
        logic [15:0] npc;
        logic [2:0]  sr;
        logic [15:0] x_ir;
        logic [15:0] x_npc;
        logic [2:0]  x_sr;
        logic [5:0]  x_e;
        logic [1:0]  x_w;
        logic        x_m;
        logic        x_v;
        logic        x_ill;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] x_ir, input logic [15:0] x_npc,
                             input logic [2:0] x_sr, input logic [5:0] x_e, input logic [1:0] x_w,
                             input logic x_m, input logic x_v, input logic x_ill);
        check({tag, ".IR"},          IR,                   x_ir);
        check({tag, ".npc_out"},     npc_out,              x_npc);
        check({tag, ".Sr_out"},      {13'd0, Sr_out},      {13'd0, x_sr});
        check({tag, ".E_Control"},   {10'd0, E_Control},   {10'd0, x_e});
        check({tag, ".W_Control"},   {14'd0, W_Control},   {14'd0, x_w});
        check({tag, ".Mem_Control"}, {15'd0, Mem_Control}, {15'd0, x_m});
        check({tag, ".dec_valid"},   {15'd0, dec_valid},   {15'd0, x_v});
`ifdef DECODE_ILLEGAL_OP_EN
        check({tag, ".illegal_op"},  {15'd0, illegal_op}, {15'd0, x_ill});
`else
        if (x_ill === 1'bx) $display("unexpected x in expectation for %s", tag);
`endif
    endtask

    task automatic step(input logic rst, input logic en, input logic [15:0] instr,
                        input logic [15:0] npc, input logic [2:0] sr);
        reset      = rst;
        en_decode  = en;
        instr_dout = instr;
        npc_in     = npc;
        Sr         = sr;
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t mk(logic rst, logic en, logic [15:0] instr, logic [15:0] npc, logic [2:0] sr,
                                logic [15:0] x_ir, logic [15:0] x_npc, logic [2:0] x_sr, logic [5:0] x_e,
                                logic [1:0] x_w, logic x_m, logic x_v, logic x_ill);
        vec_t v;
        v.rst = rst; v.en = en; v.instr = instr; v.npc = npc; v.sr = sr;
        v.x_ir = x_ir; v.x_npc = x_npc; v.x_sr = x_sr; v.x_e = x_e;
        v.x_w = x_w; v.x_m = x_m; v.x_v = x_v; v.x_ill = x_ill;
        return v;
    endfunction

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].instr, vecs[i].npc, vecs[i].sr);
            check_all($sformatf("v%0d", i), vecs[i].x_ir, vecs[i].x_npc, vecs[i].x_sr, vecs[i].x_e,
                      vecs[i].x_w, vecs[i].x_m, vecs[i].x_v, vecs[i].x_ill);
        end
    endtask

    initial begin
        //            rst  en   instr     npc       sr      IR        npc       sr      E        W      M     V     ill
        vecs.push_back(mk(1, 1, 16'h1234, 16'h0000, 3'b000, 16'h0000, 16'h0000, 3'b000, 6'h00, 2'd0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1, 1, 16'h1234, 16'h0000, 3'b000, 16'h0000, 16'h0000, 3'b000, 6'h00, 2'd0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(0, 1, 16'h1042, 16'h3001, 3'b010, 16'h1042, 16'h3001, 3'b010, 6'h01, 2'd0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(0, 1, 16'h1065, 16'h3002, 3'b001, 16'h1065, 16'h3002, 3'b001, 6'h00, 2'd0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(0, 1, 16'hA403, 16'h3005, 3'b100, 16'hA403, 16'h3005, 3'b100, 6'h06, 2'd1, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(0, 1, 16'h6A42, 16'h3006, 3'b100, 16'h6A42, 16'h3006, 3'b100, 6'h08, 2'd1, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(0, 1, 16'hE5FF, 16'h3007, 3'b010, 16'hE5FF, 16'h3007, 3'b010, 6'h06, 2'd2, 1'b0, 1'b1, 1'b0));
        // index 7 onward runs after the hold sequence
        vecs.push_back(mk(1, 1, 16'hC1C0, 16'h3010, 3'b001, 16'h0000, 16'h0000, 3'b000, 6'h00, 2'd0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(0, 1, 16'hC1C0, 16'h3010, 3'b001, 16'hC1C0, 16'h3010, 3'b001, 6'h0C, 2'd0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(0, 1, 16'hD000, 16'h3011, 3'b000, 16'hD000, 16'h3011, 3'b000, 6'h00, 2'd0, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(0, 1, 16'h9A7F, 16'h3012, 3'b100, 16'h9A7F, 16'h3012, 3'b100, 6'h20, 2'd0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(0, 1, 16'h3200, 16'h3013, 3'b010, 16'h3200, 16'h3013, 3'b010, 6'h06, 2'd0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(0, 1, 16'hB1FF, 16'h3014, 3'b010, 16'hB1FF, 16'h3014, 3'b010, 6'h06, 2'd0, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(0, 1, 16'h5020, 16'h3015, 3'b001, 16'h5020, 16'h3015, 3'b001, 6'h10, 2'd0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(0, 1, 16'h5001, 16'h3016, 3'b001, 16'h5001, 16'h3016, 3'b001, 6'h11, 2'd0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(0, 1, 16'h0E02, 16'h3017, 3'b100, 16'h0E02, 16'h3017, 3'b100, 6'h06, 2'd0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(0, 1, 16'h2202, 16'h3018, 3'b100, 16'h2202, 16'h3018, 3'b100, 6'h06, 2'd1, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(0, 1, 16'h7040, 16'h3019, 3'b010, 16'h7040, 16'h3019, 3'b010, 6'h08, 2'd0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(0, 1, 16'hF025, 16'h301A, 3'b010, 16'hF025, 16'h301A, 3'b010, 6'h00, 2'd0, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(0, 1, 16'h4800, 16'h301B, 3'b001, 16'h4800, 16'h301B, 3'b001, 6'h00, 2'd0, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(0, 1, 16'h8000, 16'h301C, 3'b001, 16'h8000, 16'h301C, 3'b001, 6'h00, 2'd0, 1'b0, 1'b1, 1'b1));

        reset = 1'b1; en_decode = 1'b0; instr_dout = '0; npc_in = '0; Sr = '0;
        @(negedge clock);

        run_vecs(0, 6);

        // Disabled for 3 cycles with a different word on the bus: LEA state must hold
        for (int c = 0; c < 3; c++) begin
            step(0, 0, 16'h5000, 16'h4000, 3'b111);
            check_all($sformatf("hold%0d", c), 16'hE5FF, 16'h3007, 3'b010, 6'h06, 2'd2, 1'b0, 1'b0, 1'b0);
        end

        run_vecs(7, vecs.size() - 1);

        // Reset while disabled clears, and the cleared state then holds with en_decode low
        step(1, 0, 16'hA403, 16'h3005, 3'b100);
        check_all("rst_dis", 16'h0000, 16'h0000, 3'b000, 6'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        step(0, 0, 16'hA403, 16'h3005, 3'b100);
        check_all("post_rst_hold", 16'h0000, 16'h0000, 3'b000, 6'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        step(0, 1, 16'hA403, 16'h3005, 3'b100);
        check_all("post_rst_cap", 16'hA403, 16'h3005, 3'b100, 6'h06, 2'd1, 1'b1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
